// File: rtl/comb_feedback_stage.sv
// Feedback comb filter y[n] = x[n] + g*y[n-D] with a circular delay line in block RAM.
// Define COMB_SAT_CNT_EN to add the saturating sat_count output that counts clipped samples.
module comb_feedback_stage #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12,
    parameter int GAIN_W = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    input  logic              source_ready,
    input  logic [GAIN_W-1:0] gain,
    input  logic [ADDR_W-1:0] delay_len,
`ifdef COMB_SAT_CNT_EN
    output logic [15:0]       sat_count,
`endif
    output logic [2:0]        dbg_state_o
);

    // Handshakes: a sample moves on a rising edge where valid && ready are both 1;
    // ready never depends combinationally on valid, and source_data is stable while source_valid is 1.

    localparam int FRAC   = GAIN_W - 1;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RD    = 3'd2,
        S_MUL   = 3'd3,
        S_SUM   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          wr_ptr_q;
    logic [ADDR_W-1:0]          clr_cnt_q;
    logic [ADDR_W-1:0]          d_q;
    logic signed [DATA_W-1:0]   x_q;
    logic signed [GAIN_W-1:0]   g_q;
    logic signed [DATA_W-1:0]   ram_q;
    logic signed [PROD_W-1:0]   p_q;
    logic [DATA_W-1:0]          source_data_q;
    logic                       source_valid_q;
    logic                       sink_ready_q;

    logic [DATA_W-1:0]          mem [2**ADDR_W];

    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W:0]            s_d;
    logic                       clip_d;
    logic [DATA_W-1:0]          y_d;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_waddr;
    logic [DATA_W-1:0]          ram_wdata;
    logic                       unused_p_frac;

    assign sink_ready    = sink_ready_q;
    assign source_valid  = source_valid_q;
    assign source_data   = source_data_q;
    assign dbg_state_o   = state_q;
    assign unused_p_frac = ^p_q[FRAC-1:0];

    // Taking bits [FRAC +: DATA_W+1] of the product is the arithmetic shift by FRAC, floor rounding.
    always_comb begin
        rd_addr   = wr_ptr_q - d_q;
        s_d       = {x_q[DATA_W-1], x_q} + p_q[FRAC +: DATA_W+1];
        clip_d    = s_d[DATA_W] ^ s_d[DATA_W-1];
        y_d       = s_d[DATA_W-1:0];
        if (clip_d) begin
            y_d = s_d[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        ram_we    = 1'b0;
        ram_waddr = wr_ptr_q;
        ram_wdata = y_d;
        if (state_q == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = '0;
        end else if (state_q == S_SUM) begin
            ram_we    = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= S_CLEAR;
            wr_ptr_q       <= '0;
            clr_cnt_q      <= '0;
            d_q            <= ADDR_ONE;
            x_q            <= '0;
            g_q            <= '0;
            p_q            <= '0;
            source_data_q  <= '0;
            source_valid_q <= 1'b0;
            sink_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_ONE;
                    if (clr_cnt_q == '1) begin
                        state_q      <= S_IDLE;
                        sink_ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (sink_valid && sink_ready_q) begin
                        x_q          <= sink_data;
                        g_q          <= gain;
                        d_q          <= (delay_len == '0) ? ADDR_ONE : delay_len;
                        sink_ready_q <= 1'b0;
                        state_q      <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    p_q     <= PROD_W'(g_q) * PROD_W'(ram_q);
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    source_data_q  <= y_d;
                    source_valid_q <= 1'b1;
                    wr_ptr_q       <= wr_ptr_q + ADDR_ONE;
                    state_q        <= S_OUT;
                end
                S_OUT: begin
                    if (source_ready) begin
                        source_valid_q <= 1'b0;
                        sink_ready_q   <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q        <= S_CLEAR;
                    clr_cnt_q      <= '0;
                    source_valid_q <= 1'b0;
                    sink_ready_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef COMB_SAT_CNT_EN
    logic [15:0] sat_count_q;
    assign sat_count = sat_count_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sat_count_q <= '0;
        end else if (state_q == S_SUM && clip_d && sat_count_q != 16'hFFFF) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end
`endif

endmodule
